// File: rtl/uop_pkg.sv
// Shared micro-op fetch types: default geometry, the per-lane instruction record and bundle/pointer typedefs.
// Pure declarations; no logic, no latency, no flow control.
package uop_pkg;
    localparam int UOP_BUF_SIZE_DEF = 64;
    localparam int FETCH_WIDTH_DEF  = 2;
    localparam int UOP_ADDR_W_DEF   = $clog2(UOP_BUF_SIZE_DEF);

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] operands;
    } fetched_instruction;

    typedef fetched_instruction [FETCH_WIDTH_DEF-1:0] uop_bundle_t;
    typedef logic [UOP_ADDR_W_DEF:0]                 uop_ptr_t;
endpackage

// File: rtl/uop_fetch_skid.sv
// Two-entry registered FIFO between buffer fetch and decode; enqueued data is on head one cycle later.
// Backpressure is exported only as the registered q_count, so deq never reaches the enqueue side combinationally.
module uop_fetch_skid #(
    parameter type T = logic [7:0]
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       enq,
    input  T           enq_dat,
    input  logic       deq,
    output logic [1:0] q_count,
    output logic       vld,
    output T           head
);
    logic [1:0] count_q, count_d;
    T           e0_q, e0_d;
    T           e1_q, e1_d;
    logic       do_enq, do_deq;

    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        do_deq  = deq && (count_q != 2'd0);
        do_enq  = enq && ((count_q != 2'd2) || do_deq);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_enq, do_deq})
                2'b11: begin
                    // Head leaves; the new entry lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        e0_d = enq_dat;
                    end else begin
                        e0_d = e1_q;
                        e1_d = enq_dat;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) e0_d = enq_dat;
                    else                 e1_d = enq_dat;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign q_count = count_q;
    assign vld     = (count_q != 2'd0);
    assign head    = e0_q;
endmodule

// File: rtl/uop_fetch_wide.sv
// Reads FETCH_WIDTH-lane bundles from the circular uop buffer; a bundle read in cycle t is on out_* at t+1.
// Decode stalls only fill the 2-entry skid queue; fetch stops on the registered occupancy, never on out_ready.
module uop_fetch_wide
    import uop_pkg::*;
#(
    parameter int UOP_BUF_SIZE = UOP_BUF_SIZE_DEF,
    parameter int FETCH_WIDTH  = FETCH_WIDTH_DEF,
    parameter int ADDR_W       = $clog2(UOP_BUF_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   redirect,
    input  logic [ADDR_W:0]                        redirect_ptr,
    input  logic [ADDR_W:0]                        wr_ptr,
    output logic [ADDR_W:0]                        rd_ptr,
    input  fetched_instruction [FETCH_WIDTH-1:0]   rd_bundle,
    input  logic [FETCH_WIDTH-1:0]                 rd_mask,
    output logic                                   rd_en,
    output logic                                   empty,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output fetched_instruction [FETCH_WIDTH-1:0]   out_bundle,
    output logic [FETCH_WIDTH-1:0]                 out_mask,
    output logic [ADDR_W-1:0]                      out_idx
);
    typedef struct packed {
        fetched_instruction [FETCH_WIDTH-1:0] bundle;
        logic [FETCH_WIDTH-1:0]               mask;
        logic [ADDR_W-1:0]                    idx;
    } entry_t;

    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]      q_count;
    logic            enq, deq;
    entry_t          enq_dat, head;

    assign empty = (rd_ptr_q == wr_ptr);
    assign rd_en = !reset && !redirect && !empty && (q_count < 2'd2);
    // All-invalid bundles still retire from the buffer but never reach decode.
    assign enq   = rd_en && (|rd_mask);
    // Decode is flushed by the same redirect, so its handshake that cycle is void.
    assign deq   = out_valid && out_ready && !redirect;

    always_comb begin
        enq_dat.bundle = rd_bundle;
        enq_dat.mask   = rd_mask;
        enq_dat.idx    = rd_ptr_q[ADDR_W-1:0];
    end

    // The wrap bit rides along in the carry, giving modulo 2*UOP_BUF_SIZE for free.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (redirect)   rd_ptr_d = redirect_ptr;
        else if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_ptr_q <= '0;
        else       rd_ptr_q <= rd_ptr_d;
    end

    uop_fetch_skid #(.T(entry_t)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect),
        .enq     (enq),
        .enq_dat (enq_dat),
        .deq     (deq),
        .q_count (q_count),
        .vld     (out_valid),
        .head    (head)
    );

    assign rd_ptr     = rd_ptr_q;
    assign out_bundle = head.bundle;
    assign out_mask   = head.mask;
    assign out_idx    = head.idx;
endmodule

// File: tb/tb_uop_fetch_wide.sv
// Directed and randomised checks of uop_fetch_wide against a queue-based reference model of fetch and decode handoff.
module tb_uop_fetch_wide;
    import uop_pkg::*;

    logic        clk;
    logic        reset;
    logic        redirect;
    uop_ptr_t    redirect_ptr;
    uop_ptr_t    wr_ptr;
    uop_ptr_t    rd_ptr;
    uop_bundle_t rd_bundle;
    logic [1:0]  rd_mask;
    logic        rd_en;
    logic        empty;
    logic        out_valid;
    logic        out_ready;
    uop_bundle_t out_bundle;
    logic [1:0]  out_mask;
    logic [5:0]  out_idx;

    uop_bundle_t buf_mem  [64];
    logic [1:0]  mask_mem [64];

    assign rd_bundle = buf_mem[rd_ptr[5:0]];
    assign rd_mask   = mask_mem[rd_ptr[5:0]];

    uop_fetch_wide #(.UOP_BUF_SIZE(64), .FETCH_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_ptr (redirect_ptr),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .rd_bundle    (rd_bundle),
        .rd_mask      (rd_mask),
        .rd_en        (rd_en),
        .empty        (empty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bundle   (out_bundle),
        .out_mask     (out_mask),
        .out_idx      (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        uop_bundle_t b;
        logic [1:0]  m;
        logic [5:0]  idx;
    } exp_t;

    int       n_assert = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    int       en_cnt   = 0;
    int       first_en = -1;
    int       got_idx[$];
    int       got_cyc[$];
    exp_t     m_q[$];
    uop_ptr_t m_ptr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        got_idx.delete();
        got_cyc.delete();
        en_cnt   = 0;
        first_en = -1;
    endtask

    // One clock: check DUT against the model mid-cycle, then advance the model.
    task automatic step();
        logic m_empty;
        logic m_en;
        exp_t e;
        #1;
        m_empty = (m_ptr == wr_ptr);
        m_en    = !reset && !redirect && !m_empty && (m_q.size() < 2);
        chk("rd_ptr", 64'(rd_ptr), 64'(m_ptr));
        chk("empty", 64'(empty), 64'(m_empty));
        chk("rd_en", 64'(rd_en), 64'(m_en));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("out_idx", 64'(out_idx), 64'(m_q[0].idx));
            chk("out_mask", 64'(out_mask), 64'(m_q[0].m));
            chk("out_bundle", 64'(out_bundle), 64'(m_q[0].b));
        end
        if (out_valid) chk("mask_nonzero", 64'(out_mask != 2'b00), 64'(1));
        if (rd_en) begin
            chk("en_legal", 64'({empty, (m_q.size() == 2)}), 64'(0));
            en_cnt++;
            if (first_en < 0) first_en = cyc;
        end
        if (!reset && !redirect && out_valid && out_ready) begin
            got_idx.push_back(int'(out_idx));
            got_cyc.push_back(cyc);
        end
        if (reset) begin
            m_ptr = '0;
            m_q.delete();
        end else if (redirect) begin
            m_ptr = redirect_ptr;
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_en) begin
                if (mask_mem[m_ptr[5:0]] != 2'b00) begin
                    e.b   = buf_mem[m_ptr[5:0]];
                    e.m   = mask_mem[m_ptr[5:0]];
                    e.idx = m_ptr[5:0];
                    m_q.push_back(e);
                end
                m_ptr = m_ptr + 7'd1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_list(input string tag, input int exp_idx[$]);
        chk({tag, "_count"}, 64'(got_idx.size()), 64'(exp_idx.size()));
        for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++)
            chk({tag, "_idx"}, 64'(got_idx[k]), 64'(exp_idx[k]));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            buf_mem[i][0].opcode   = 8'(i);
            buf_mem[i][0].operands = 24'(i * 3 + 1);
            buf_mem[i][1].opcode   = 8'(255 - i);
            buf_mem[i][1].operands = 24'(i * 7 + 5);
            mask_mem[i]            = 2'b11;
        end
        mask_mem[1] = 2'b01;
        mask_mem[2] = 2'b10;
        reset = 1'b1; redirect = 1'b0; redirect_ptr = '0; wr_ptr = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        run(2);
        chk("rst_rd_ptr", 64'(rd_ptr), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_mask", 64'(out_mask), 64'(0));
        chk("rst_out_idx", 64'(out_idx), 64'(0));

        // Three bundles with decode always ready.
        reset = 1'b0; wr_ptr = 7'd3; out_ready = 1'b1;
        clr();
        run(6);
        chk("s1_en_cnt", 64'(en_cnt), 64'(3));
        chk_list("s1", '{0, 1, 2});
        if (got_cyc.size() == 3) begin
            chk("s1_latency", 64'(got_cyc[0] - first_en), 64'(1));
            chk("s1_back2back", 64'(got_cyc[2] - got_cyc[0]), 64'(2));
        end
        chk("s1_empty", 64'(empty), 64'(1));

        // Decode stalled: queue fills to two and fetch stops.
        reset = 1'b1; step();
        reset = 1'b0; out_ready = 1'b0; wr_ptr = 7'd10;
        clr();
        run(5);
        chk("s2_en_cnt", 64'(en_cnt), 64'(2));
        chk("s2_rd_ptr", 64'(rd_ptr), 64'(2));
        chk("s2_out_idx", 64'(out_idx), 64'(0));
        out_ready = 1'b1;
        clr();
        run(12);
        chk_list("s2", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        if (got_cyc.size() == 10) chk("s2_no_gap", 64'(got_cyc[9] - got_cyc[0]), 64'(9));

        // Wrap across the end of the buffer.
        redirect = 1'b1; redirect_ptr = 7'd62; wr_ptr = {1'b1, 6'd2};
        step();
        redirect = 1'b0;
        clr();
        run(7);
        chk_list("wrap", '{62, 63, 0, 1});
        if (got_cyc.size() == 4) chk("wrap_no_gap", 64'(got_cyc[3] - got_cyc[0]), 64'(3));
        chk("wrap_rd_ptr", 64'(rd_ptr), 64'({1'b1, 6'd2}));
        chk("wrap_empty", 64'(empty), 64'(1));

        // All-invalid bundle at index 4 is consumed but dropped.
        mask_mem[4] = 2'b00;
        redirect = 1'b1; redirect_ptr = 7'd3; wr_ptr = 7'd6;
        step();
        redirect = 1'b0;
        clr();
        run(6);
        chk("drop_en_cnt", 64'(en_cnt), 64'(3));
        chk_list("drop", '{3, 5});
        mask_mem[4] = 2'b11;

        // Redirect while the queue holds two entries; wr_ptr moves in the same cycle.
        out_ready = 1'b0; redirect = 1'b1; redirect_ptr = 7'd10; wr_ptr = 7'd30;
        step();
        redirect = 1'b0;
        run(4);
        chk("rdr_full_valid", 64'(out_valid), 64'(1));
        redirect = 1'b1; redirect_ptr = 7'd20; wr_ptr = 7'd40; out_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("rdr_valid_t1", 64'(out_valid), 64'(0));
        chk("rdr_ptr_t1", 64'(rd_ptr), 64'(20));
        step();
        chk("rdr_valid_t2", 64'(out_valid), 64'(1));
        chk("rdr_idx_t2", 64'(out_idx), 64'(20));
        reset = 1'b1; redirect = 1'b1; redirect_ptr = 7'd33;
        step();
        reset = 1'b0; redirect = 1'b0;
        chk("rst_over_rdr", 64'(rd_ptr), 64'(0));

        // Randomised soak against the reference model.
        for (int i = 0; i < 64; i++) mask_mem[i] = 2'($urandom_range(0, 3));
        for (int n = 0; n < 800; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (7'(wr_ptr - m_ptr) < 7'd60 && $urandom_range(0, 2) != 0) wr_ptr = wr_ptr + 7'd1;
            redirect = ($urandom_range(0, 59) == 0);
            if (redirect) redirect_ptr = wr_ptr - 7'($urandom_range(0, 20));
            step();
        end
        redirect = 1'b0;
        out_ready = 1'b1;
        run(70);
        chk("soak_drained", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uop_fetch_wide.md
# uop_fetch_wide

Parametrised successor of the two-slot micro-op fetch stage. It reads FETCH_WIDTH-lane bundles from the circular micro-op buffer and tracks occupancy against the producer's write pointer. It redirects on pipeline flush and drops all-invalid bundles. Results are presented to decode through a 2-entry registered skid queue, so decode backpressure never reaches the buffer read path combinationally.

## Interface
Parameters:
- UOP_BUF_SIZE, 64, buffer depth in bundles; power of two, ≥ 2.
- FETCH_WIDTH, 2, lanes per bundle; 1..8.
- ADDR_W, $clog2(UOP_BUF_SIZE), derived; not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- redirect  in  1  flush; reload read pointer.
- redirect_ptr  in  ADDR_W+1  new read pointer, including wrap bit.
- wr_ptr  in  ADDR_W+1  producer write pointer, including wrap bit.
- rd_ptr  out  ADDR_W+1  current read pointer; low ADDR_W bits address the buffer.
- rd_bundle  in  uop_bundle_t  combinational buffer read data at rd_ptr[ADDR_W-1:0].
- rd_mask  in  FETCH_WIDTH  per-lane valid for rd_bundle.
- rd_en  out  1  bundle consumed this cycle; the producer may free the entry.
- empty  out  1  rd_ptr == wr_ptr.
- out_valid  out  1  head of skid queue valid.
- out_ready  in  1  decode accepts the head.
- out_bundle  out  uop_bundle_t  head bundle.
- out_mask  out  FETCH_WIDTH  head lane mask; never all-zero while out_valid.
- out_idx  out  ADDR_W  buffer index the head came from.

## Operation
- Pointer arithmetic:
  - empty = (rd_ptr == wr_ptr).
  - Full and wrap are implied by the wrap bit.
  - rd_ptr increments modulo 2·UOP_BUF_SIZE.
  - Index UOP_BUF_SIZE-1 is followed by index 0 with the wrap bit toggled.
- Fetch condition: rd_en = !reset && !redirect && !empty && (q_count < 2).
  - q_count is the registered occupancy; out_ready is deliberately excluded.
- On rd_en:
  - rd_ptr advances by 1.
  - If rd_mask != 0, {rd_bundle, rd_mask, rd_ptr[ADDR_W-1:0]} is enqueued.
  - If rd_mask == 0, the bundle is consumed but not enqueued.
- Dequeue occurs when out_valid && out_ready.
  - Enqueue and dequeue in the same cycle leave q_count unchanged; order is preserved.
- Redirect:
  - rd_ptr <= redirect_ptr; q_count <= 0; no fetch and no dequeue effect that cycle.
  - Any out_ready handshake in the redirect cycle is void; decode is flushed by the same signal.
- Priority: reset > redirect > normal operation.
- Reset: rd_ptr = 0, q_count = 0, out_valid = 0, out_mask = 0, out_idx = 0.
  - out_bundle is don't-care after reset.
  - empty follows wr_ptr combinationally.
- wr_ptr changing during a redirect is legal; empty is re-evaluated the following cycle.

## Timing
- Bundle at rd_ptr is read in cycle t and visible on out_* at t+1 when the queue was empty.
- rd_en, empty, and rd_ptr are combinational only from registers, wr_ptr, and redirect.
  - No path from out_ready to rd_en or rd_ptr.
- Sustained throughput is 1 bundle/cycle while !empty and out_ready stays high; q_count settles at 1.
- out_ready low:
  - The queue fills to 2 within 2 fetches, then rd_en = 0.
  - Restart: out_valid stays high on the cycle after out_ready returns; no bubble.
- After redirect in cycle t:
  - rd_en may assert in t+1.
  - First post-redirect bundle is on out_* at t+2.
- Wrap: no stall or bubble crossing index UOP_BUF_SIZE-1 → 0.

## Structure
- Shared package uop_pkg:
  - UOP_BUF_SIZE and FETCH_WIDTH defaults.
  - fetched_instruction typedef.
  - uop_bundle_t = fetched_instruction [FETCH_WIDTH].
  - Pointer typedef uop_ptr_t (ADDR_W+1 bits).
- Sub-module uop_fetch_skid: 2-entry registered FIFO, parametrised on payload type.
  - Outputs q_count, valid, and head.
  - Inputs enq, deq, and flush.
- Top level holds rd_ptr, the fetch condition, mask-zero drop, and redirect priority.

## Test plan
- Reset then wr_ptr = 3 with out_ready = 1:
  - rd_en high 3 cycles.
  - out_idx = 0, 1, 2 on consecutive cycles starting 1 cycle after the first rd_en.
  - empty = 1 after.
- out_ready held 0 with wr_ptr = 10:
  - Exactly 2 rd_en pulses; rd_ptr = 2; out_idx stays 0.
  - Releasing out_ready yields idx 0, 1, 2, … with no gap.
- UOP_BUF_SIZE = 8, rd_ptr = 6, wr_ptr = {1, 3'd2}:
  - Fetched indices 6, 7, 0, 1.
  - Final rd_ptr = {1, 3'd2}; empty = 1.
- rd_mask = 0 at index 4 within indices 3..5:
  - Outputs carry idx 3 then 5.
  - rd_en pulses 3 times.
  - out_mask never 0 while out_valid.
- Redirect to 20 with queue holding 2 entries:
  - out_valid = 0 next cycle; rd_ptr = 20.
  - out_idx = 20 two cycles after the redirect.
  - Redirect asserted with reset gives rd_ptr = 0.
- Randomised wr_ptr/out_ready soak against a reference queue model:
  - Order, indices, and masks match.
  - rd_en never fires when empty or when q_count = 2.
